uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
Bus initiator for the scope's register-mapped slaves (DDS control, sampling, capture). Parses the byte stream from the UART receiver into fixed-format command frames. Each valid frame produces a single-cycle register write on m_wr/m_addr/m_wrdata. Malformed, truncated or stalled frames are dropped and flagged; they never produce a write.

Parameters:
TIMEOUT_CYC, 100000, max clk cycles allowed between consecutive bytes of one frame (2 ms at 50 MHz)
HDR0, 8'h55, first header byte
HDR1, 8'hA5, second header byte
TAIL, 8'hF0, frame terminator byte

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
rx_data  input  8  received byte, valid when rx_done=1
rx_done  input  1  one-cycle strobe, new byte on rx_data
m_wr  output  1  one-cycle register write strobe
m_addr  output  8  register address, valid with m_wr
m_wrdata  output  16  register write data, valid with m_wr
frame_err  output  1  one-cycle strobe, frame discarded
busy  output  1  high while a frame is partially received (state != S_H0)

Behaviour:
- Reset: clk/rst as decided (rst asynchronous, active-low). State S_H0; m_wr=0, m_addr=0, m_wrdata=0, frame_err=0, busy=0; timeout counter=0; shadow regs addr/dh/dl=0.
- Frame format: HDR0, HDR1, ADDR, DATA_H, DATA_L, [CS if CMD_CHECKSUM_EN], TAIL.
- State advances only on cycles with rx_done=1.
- FSM transitions:
  - S_H0: byte==HDR0 -> S_H1; any other byte -> stay.
  - S_H1: byte==HDR1 -> S_ADDR; byte==HDR0 -> stay (resync); any other byte -> S_H0, no error.
  - S_ADDR: latch addr -> S_DH.
  - S_DH: latch dh -> S_DL.
  - S_DL: latch dl -> S_CS (feature on) or S_TAIL (feature off).
  - S_TAIL: byte==TAIL -> commit, then S_H0; any other byte -> frame_err, then S_H0.
- Commit: at the edge after the TAIL byte is sampled, m_wr=1 for exactly 1 cycle, m_addr=addr, m_wrdata={dh,dl}. m_addr/m_wrdata then hold until the next commit. Latency is 1 clk from the rx_done of TAIL.
- Back-to-back frames: the next HDR0 may arrive the cycle after TAIL and is accepted normally.
- Timeout:
  - Counter clears on every rx_done and whenever state is S_H0; otherwise it increments.
  - When counter==TIMEOUT_CYC-1 and rx_done=0: go to S_H0, frame_err=1 for 1 cycle, counter clears.
  - If rx_done coincides with the terminal count, the byte is processed and no timeout occurs.
- Errors never modify m_addr/m_wrdata and never assert m_wr. frame_err and m_wr are never high in the same cycle.
- Reset mid-frame: immediate return to reset values; the partial frame is lost without frame_err.
- Counter width: $clog2(TIMEOUT_CYC)+1 bits. Counter saturates at terminal count and never wraps.

Optional Feature:
CMD_CHECKSUM_EN
- Defined: frame includes a CS byte between DATA_L and TAIL, with CS = (ADDR+DATA_H+DATA_L) mod 256 (8-bit wrap).
  - In S_CS: match -> S_TAIL; mismatch -> frame_err 1 cycle, then S_H0, no write.
- Undefined: no S_CS state; DATA_L is followed directly by TAIL; no checksum logic is synthesised.

Test Plan:
- Nominal write (feature off): bytes 55 A5 03 12 34 F0 -> one m_wr pulse 1 clk after F0's rx_done, m_addr=8'h03, m_wrdata=16'h1234, frame_err stays 0.
- Bad tail: 55 A5 03 12 34 00 -> no m_wr, frame_err 1 cycle, busy drops; then 55 A5 04 00 01 F0 -> m_addr=04, m_wrdata=0001.
- Resync: 55 55 A5 07 AB CD F0 -> m_addr=07, m_wrdata=ABCD; garbage 11 22 before a frame -> ignored, no frame_err.
- Timeout (TIMEOUT_CYC=100): 55 A5 03, then idle 100 cycles -> frame_err pulse, busy=0; following full frame decodes correctly. A byte arriving exactly at count 99 is accepted, no error.
- Checksum (CMD_CHECKSUM_EN): 55 A5 01 FF 02 02 F0 -> write addr 01, data FF02 (01+FF+02 = 0x102 -> 0x02). Same frame with CS=03 -> frame_err, no write.
- Reset mid-frame: assert rst after 55 A5 09 -> all outputs 0 immediately; release, send full frame -> correct single write.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder_if
// Signal bundle between the UART byte receiver, the command decoder and the
// register-mapped slaves it writes to.
//
//   rx_data   [7:0]  received byte, valid when rx_done=1
//   rx_done          one-cycle strobe, new byte on rx_data
//   m_wr             one-cycle register write strobe
//   m_addr    [7:0]  register address, valid with m_wr (held until next write)
//   m_wrdata  [15:0] register write data, valid with m_wr (held until next write)
//   frame_err        one-cycle strobe, a frame was discarded
//   busy             high while a frame is partially received
//
// Modports:
//   master : the decoder (consumes bytes, initiates register writes)
//   slave  : the environment around it (byte source and register slaves)
// -----------------------------------------------------------------------------
interface uart_cmd_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        m_wr;
    logic [7:0]  m_addr;
    logic [15:0] m_wrdata;
    logic        frame_err;
    logic        busy;

    modport master (
        input  rx_data,
        input  rx_done,
        output m_wr,
        output m_addr,
        output m_wrdata,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_data,
        output rx_done,
        input  m_wr,
        input  m_addr,
        input  m_wrdata,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
// Turns the UART receiver byte stream into register writes for the scope's
// register-mapped slaves (DDS control, sampling, capture).
//
// Frame: HDR0 HDR1 ADDR DATA_H DATA_L [CS] TAIL
//   A complete frame with a correct TAIL produces one m_wr pulse one clock
//   after the TAIL byte's rx_done, with m_addr=ADDR, m_wrdata={DATA_H,DATA_L}.
//   Bad TAIL, bad CS or a stalled frame (no byte for TIMEOUT_CYC cycles)
//   discards the frame and pulses frame_err instead; no write happens.
//
// Optional build macro:
//   CMD_CHECKSUM_EN  when defined, the frame carries CS between DATA_L and TAIL,
//                    CS = (ADDR + DATA_H + DATA_L) mod 256. When undefined no
//                    checksum state or logic exists.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-low reset
//   bus  uart_cmd_decoder_if.master (rx_data/rx_done in; m_wr, m_addr,
//        m_wrdata, frame_err, busy out)
//
// Parameters:
//   TIMEOUT_CYC  max clk cycles between consecutive bytes of one frame
//   HDR0, HDR1   header bytes
//   TAIL         terminator byte
// -----------------------------------------------------------------------------
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'hA5,
    parameter logic [7:0]  TAIL        = 8'hF0
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_decoder_if.master bus
);

    // Counter is one bit wider than needed to hold TIMEOUT_CYC-1 so the
    // terminal count never sits at the top of the range.
    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_H0   = 3'd0;
    localparam logic [2:0] S_H1   = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DH   = 3'd3;
    localparam logic [2:0] S_DL   = 3'd4;
    localparam logic [2:0] S_TAIL = 3'd5;
`ifdef CMD_CHECKSUM_EN
    localparam logic [2:0] S_CS   = 3'd6;
`endif

    logic [2:0]       state_reg,     state_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic [7:0]       addr_reg,      addr_next;
    logic [7:0]       dh_reg,        dh_next;
    logic [7:0]       dl_reg,        dl_next;
    logic             m_wr_reg,      m_wr_next;
    logic [7:0]       m_addr_reg,    m_addr_next;
    logic [15:0]      m_wrdata_reg,  m_wrdata_next;
    logic             frame_err_reg, frame_err_next;

    logic             timeout_hit;

`ifdef CMD_CHECKSUM_EN
    logic [7:0]       cs_calc;
    // 8-bit sum wraps naturally, giving the mod-256 checksum.
    assign cs_calc = addr_reg + dh_reg + dl_reg;
`endif

    // A byte arriving on the terminal-count cycle wins over the timeout.
    assign timeout_hit = (state_reg != S_H0) && !bus.rx_done && (cnt_reg == CNT_TERM);

    // -------------------------------------------------------------------------
    // Inter-byte timeout counter: idle in S_H0, restarted by every byte,
    // saturating at the terminal count (timeout_hit clears it anyway).
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_next = cnt_reg;
        if (bus.rx_done || (state_reg == S_H0) || timeout_hit) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_TERM) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Frame parser. State only moves on rx_done, except for the timeout.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        dh_next        = dh_reg;
        dl_next        = dl_reg;
        m_addr_next    = m_addr_reg;
        m_wrdata_next  = m_wrdata_reg;
        m_wr_next      = 1'b0;
        frame_err_next = 1'b0;

        if (timeout_hit) begin
            state_next     = S_H0;
            frame_err_next = 1'b1;
        end else if (bus.rx_done) begin
            case (state_reg)
                S_H0: begin
                    if (bus.rx_data == HDR0) begin
                        state_next = S_H1;
                    end
                end
                S_H1: begin
                    // A repeated HDR0 may be the real start of a frame, so
                    // keep waiting for HDR1. Anything else is line noise and
                    // is dropped silently.
                    if (bus.rx_data == HDR1) begin
                        state_next = S_ADDR;
                    end else if (bus.rx_data != HDR0) begin
                        state_next = S_H0;
                    end
                end
                S_ADDR: begin
                    addr_next  = bus.rx_data;
                    state_next = S_DH;
                end
                S_DH: begin
                    dh_next    = bus.rx_data;
                    state_next = S_DL;
                end
                S_DL: begin
                    dl_next    = bus.rx_data;
`ifdef CMD_CHECKSUM_EN
                    state_next = S_CS;
`else
                    state_next = S_TAIL;
`endif
                end
`ifdef CMD_CHECKSUM_EN
                S_CS: begin
                    if (bus.rx_data == cs_calc) begin
                        state_next = S_TAIL;
                    end else begin
                        state_next     = S_H0;
                        frame_err_next = 1'b1;
                    end
                end
`endif
                S_TAIL: begin
                    state_next = S_H0;
                    if (bus.rx_data == TAIL) begin
                        m_wr_next     = 1'b1;
                        m_addr_next   = addr_reg;
                        m_wrdata_next = {dh_reg, dl_reg};
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
                default: begin
                    state_next = S_H0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_H0;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            dh_reg        <= '0;
            dl_reg        <= '0;
            m_wr_reg      <= 1'b0;
            m_addr_reg    <= '0;
            m_wrdata_reg  <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            dh_reg        <= dh_next;
            dl_reg        <= dl_next;
            m_wr_reg      <= m_wr_next;
            m_addr_reg    <= m_addr_next;
            m_wrdata_reg  <= m_wrdata_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign bus.m_wr      = m_wr_reg;
    assign bus.m_addr    = m_addr_reg;
    assign bus.m_wrdata  = m_wrdata_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = (state_reg != S_H0);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Directed frames followed by randomized frame streams. A byte-queue reference
// model predicts m_wr / frame_err / busy / m_addr / m_wrdata for every cycle.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decoder;

    localparam int unsigned TIMEOUT = 100;
    localparam logic [7:0]  H0 = 8'h55;
    localparam logic [7:0]  H1 = 8'hA5;
    localparam logic [7:0]  TL = 8'hF0;
`ifdef CMD_CHECKSUM_EN
    localparam int FLEN = 7;
`else
    localparam int FLEN = 6;
`endif

    logic clk;
    logic rst;
    uart_cmd_decoder_if bus();

    uart_cmd_decoder #(
        .TIMEOUT_CYC (TIMEOUT),
        .HDR0        (H0),
        .HDR1        (H1),
        .TAIL        (TL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: bytes of the partially received frame.
    logic [7:0]  pend[$];
    int          cyc      = 0;
    int          last_cyc = 0;
    logic        exp_wr;
    logic        exp_err;
    logic [7:0]  exp_addr = 8'h00;
    logic [15:0] exp_data = 16'h0000;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int sum;
        if (pend.size() == 0) begin
            if (b == H0) pend.push_back(b);
        end else if (pend.size() == 1) begin
            if (b == H1)       pend.push_back(b);
            else if (b != H0)  pend.delete();
        end else begin
            pend.push_back(b);
`ifdef CMD_CHECKSUM_EN
            if (pend.size() == 6) begin
                sum = int'(pend[2]) + int'(pend[3]) + int'(pend[4]);
                if ((sum % 256) != int'(b)) begin
                    exp_err = 1'b1;
                    pend.delete();
                end
            end
`endif
            if (pend.size() == FLEN) begin
                if (b == TL) begin
                    exp_wr   = 1'b1;
                    exp_addr = pend[2];
                    exp_data = {pend[3], pend[4]};
                end else begin
                    exp_err = 1'b1;
                end
                pend.delete();
            end
        end
    endtask

    // One clock: drive inputs, advance the model, check all outputs.
    task automatic tick(input logic done, input logic [7:0] data);
        @(negedge clk);
        bus.rx_done = done;
        bus.rx_data = data;
        cyc++;
        exp_wr  = 1'b0;
        exp_err = 1'b0;
        if (done) begin
            last_cyc = cyc;
            model_byte(data);
        end else if (pend.size() != 0 && (cyc - last_cyc) == int'(TIMEOUT)) begin
            exp_err = 1'b1;
            pend.delete();
        end
        @(posedge clk);
        #1;
        chk("m_wr",      {15'd0, bus.m_wr},      {15'd0, exp_wr});
        chk("frame_err", {15'd0, bus.frame_err}, {15'd0, exp_err});
        chk("busy",      {15'd0, bus.busy},      {15'd0, (pend.size() != 0)});
        chk("m_addr",    {8'd0, bus.m_addr},     {8'd0, exp_addr});
        chk("m_wrdata",  bus.m_wrdata,           exp_data);
    endtask

    // gap idle cycles (with junk on rx_data) then the byte itself.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) tick(1'b0, 8'($urandom));
        tick(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] t);
        send_byte(H0, 0);
        send_byte(H1, 0);
        send_byte(a, 0);
        send_byte(h, 0);
        send_byte(l, 0);
`ifdef CMD_CHECKSUM_EN
        send_byte(a + h + l, 0);
`endif
        send_byte(t, 0);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] a, h, l;
        int kind, stall_at;

        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_wr",      {15'd0, bus.m_wr},      16'h0000);
        chk("rst_frame_err", {15'd0, bus.frame_err}, 16'h0000);
        chk("rst_busy",      {15'd0, bus.busy},      16'h0000);
        chk("rst_m_addr",    {8'd0, bus.m_addr},     16'h0000);
        chk("rst_m_wrdata",  bus.m_wrdata,           16'h0000);
        rst = 1'b1;

        // Nominal write.
        send_frame(8'h03, 8'h12, 8'h34, TL);
        chk("nom_wr",   {15'd0, bus.m_wr},  16'h0001);
        chk("nom_addr", {8'd0, bus.m_addr}, 16'h0003);
        chk("nom_data", bus.m_wrdata,       16'h1234);
        tick(1'b0, 8'h00);
        chk("nom_wr_one_cycle", {15'd0, bus.m_wr}, 16'h0000);

        // Bad tail, then a good frame.
        send_frame(8'h03, 8'h12, 8'h34, 8'h00);
        chk("badtail_err",  {15'd0, bus.frame_err}, 16'h0001);
        chk("badtail_busy", {15'd0, bus.busy},      16'h0000);
        chk("badtail_hold", bus.m_wrdata,           16'h1234);
        send_frame(8'h04, 8'h00, 8'h01, TL);
        chk("after_bad_addr", {8'd0, bus.m_addr}, 16'h0004);
        chk("after_bad_data", bus.m_wrdata,       16'h0001);

        // Garbage then resync on a doubled header byte.
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(H0, 0);
        send_frame(8'h07, 8'hAB, 8'hCD, TL);
        chk("resync_addr", {8'd0, bus.m_addr}, 16'h0007);
        chk("resync_data", bus.m_wrdata,       16'hABCD);

        // Timeout after 100 idle cycles mid-frame.
        send_byte(H0, 0);
        send_byte(H1, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 100; i++) tick(1'b0, 8'h00);
        chk("timeout_err",  {15'd0, bus.frame_err}, 16'h0001);
        chk("timeout_busy", {15'd0, bus.busy},      16'h0000);
        send_frame(8'h21, 8'h43, 8'h65, TL);
        chk("post_to_data", bus.m_wrdata, 16'h4365);

        // Byte exactly at the terminal count is accepted.
        send_byte(H0, 0);
        send_byte(H1, 0);
        send_byte(8'h5A, 99);
        send_byte(8'h0F, 99);
        send_byte(8'h1E, 99);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h5A + 8'h0F + 8'h1E, 99);
`endif
        send_byte(TL, 99);
        chk("edge99_addr", {8'd0, bus.m_addr}, 16'h005A);
        chk("edge99_data", bus.m_wrdata,       16'h0F1E);

`ifdef CMD_CHECKSUM_EN
        fr = '{8'h55, 8'hA5, 8'h01, 8'hFF, 8'h02, 8'h02, 8'hF0};
        foreach (fr[i]) send_byte(fr[i], 0);
        chk("cs_addr", {8'd0, bus.m_addr}, 16'h0001);
        chk("cs_data", bus.m_wrdata,       16'hFF02);
        fr = '{8'h55, 8'hA5, 8'h01, 8'hFF, 8'h02, 8'h03};
        foreach (fr[i]) send_byte(fr[i], 0);
        chk("cs_bad_err", {15'd0, bus.frame_err}, 16'h0001);
        send_byte(8'hF0, 0);
`endif

        // Reset mid-frame clears everything immediately.
        send_byte(H0, 0);
        send_byte(H1, 0);
        send_byte(8'h09, 0);
        #1 rst = 1'b0;
        #1;
        pend.delete();
        exp_addr = 8'h00;
        exp_data = 16'h0000;
        chk("midrst_busy",   {15'd0, bus.busy},  16'h0000);
        chk("midrst_m_addr", {8'd0, bus.m_addr}, 16'h0000);
        chk("midrst_data",   bus.m_wrdata,       16'h0000);
        chk("midrst_m_wr",   {15'd0, bus.m_wr},  16'h0000);
        @(negedge clk);
        rst = 1'b1;
        send_frame(8'h09, 8'h87, 8'h65, TL);
        chk("postrst_addr", {8'd0, bus.m_addr}, 16'h0009);
        chk("postrst_data", bus.m_wrdata,       16'h8765);

        // Randomized frame streams with corruption, noise and stalls.
        for (int f = 0; f < 80; f++) begin
            kind = int'($urandom_range(0, 9));
            a = 8'($urandom);
            h = 8'($urandom);
            l = 8'($urandom);
            fr.delete();
            if (kind == 8) begin
                for (int g = 0; g < int'($urandom_range(1, 4)); g++) fr.push_back(8'($urandom));
            end
            fr.push_back(H0);
            fr.push_back(H1);
            fr.push_back(a);
            fr.push_back(h);
            fr.push_back(l);
`ifdef CMD_CHECKSUM_EN
            fr.push_back((kind == 7) ? (a + h + l + 8'h01) : (a + h + l));
`endif
            fr.push_back((kind == 6) ? 8'($urandom) : TL);
            stall_at = (kind == 9) ? int'($urandom_range(1, fr.size() - 1)) : -1;
            foreach (fr[i]) begin
                send_byte(fr[i], (i == stall_at) ? int'($urandom_range(98, 102))
                                                 : int'($urandom_range(0, 3)));
            end
        end
        repeat (3) tick(1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
